// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: FSM states,
// ROM entry layout and the rest-note constant.
package song_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_DONE
    } state_t;

    localparam int NOTE_LSB = 10;
    localparam int NOTE_W   = 6;
    localparam int DUR_LSB  = 4;
    localparam int DUR_W    = 6;
    localparam int META_LSB = 1;
    localparam int META_W   = 3;
    localparam int LAST_BIT = 0;

    localparam logic [NOTE_W-1:0] REST = '0;

    typedef struct packed {
        logic [NOTE_W-1:0] note;
        logic [DUR_W-1:0]  dur;
        logic [META_W-1:0] meta;
        logic              last;
    } entry_t;

    function automatic entry_t unpack_entry(input logic [15:0] d);
        entry_t e;
        e.note = d[NOTE_LSB +: NOTE_W];
        e.dur  = d[DUR_LSB +: DUR_W];
        e.meta = d[META_LSB +: META_W];
        e.last = d[LAST_BIT];
        return e;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Song ROM bus: address out from the sequencer,
// registered data back one cycle later.
interface song_sequencer_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/song_sequencer_beat_counter.sv
// Beats elapsed within the current note; wraps to 0 on
// the beat that completes the note's duration.
module beat_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    input  logic [5:0] duration,
    output logic       tc
);
    logic [5:0] cnt;

    assign tc = (cnt + 6'd1) == duration;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       cnt <= '0;
        else if (clear)  cnt <= '0;
        else if (enable) cnt <= tc ? 6'd0 : cnt + 6'd1;
    end
endmodule

// File: rtl/song_sequencer.sv
// Walks the song ROM, hands each note to the note player
// and times it in beats; supports pause, restart and looping.
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter bit LOOP   = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   play,
    input  logic                   restart,
    input  logic                   beat,
    song_sequencer_if.master       rom,
    output logic [5:0]             note_to_load,
    output logic [2:0]             metadata,
    output logic                   load_new_note,
    output logic                   play_enable,
    output logic                   song_done
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state, nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    entry_t            ent;
    logic [5:0]        dur_q;
    logic              last_q, load_q;
    logic              latch, clr, cnt_en, tc;

    assign ent          = unpack_entry(rom.rom_data);
    assign rom.rom_addr = addr;

    beat_counter u_beat_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    (clr),
        .enable   (cnt_en),
        .duration (dur_q),
        .tc       (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt      = state;
        addr_nxt = addr;
        latch    = 1'b0;
        clr      = 1'b0;
        cnt_en   = 1'b0;
        unique case (state)
            S_IDLE: if (play) nxt = S_FETCH;
            S_FETCH: nxt = S_LOAD;
            S_LOAD: begin
                if (ent.dur != '0) begin
                    latch = 1'b1;
                    clr   = 1'b1;
                    nxt   = S_PLAY;
                end else if (LOOP) begin
                    addr_nxt = '0;
                    nxt      = S_FETCH;
                end else begin
                    nxt = S_DONE;
                end
            end
            S_PLAY: begin
                if (beat && play) begin
                    cnt_en = 1'b1;
                    if (tc) begin
                        nxt = S_FETCH;
                        if (!last_q && addr != ADDR_MAX)
                            addr_nxt = addr + ADDR_ONE;
                        else if (LOOP)
                            addr_nxt = '0;
                        else
                            nxt = S_DONE;
                    end
                end
            end
            S_DONE: nxt = S_DONE;
            default: nxt = S_IDLE;
        endcase
        // restart overrides whatever the state wanted this cycle
        if (restart) begin
            nxt      = S_FETCH;
            addr_nxt = '0;
            latch    = 1'b0;
            clr      = 1'b1;
            cnt_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr         <= '0;
            note_to_load <= REST;
            metadata     <= '0;
            dur_q        <= '0;
            last_q       <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            addr   <= addr_nxt;
            load_q <= latch;
            if (latch) begin
                note_to_load <= ent.note;
                metadata     <= ent.meta;
                dur_q        <= ent.dur;
                last_q       <= ent.last;
            end
        end
    end

    assign load_new_note = load_q & ~restart;
    assign play_enable   = (state == S_PLAY) && play;
    assign song_done     = (state == S_DONE);
endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, meaning the song ROM address width.
REQ-002 SHALL have parameter LOOP, default 0, meaning that 1 restarts the song at address 0 instead of finishing.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port play, input, 1, a level: 1 runs, 0 pauses.
REQ-006 SHALL have port restart, input, 1, a one-cycle pulse returning playback to address 0.
REQ-007 SHALL have port beat, input, 1, a one-cycle beat pulse from beat_generator.
REQ-008 SHALL have port rom_addr, output, ADDR_W, the song ROM address.
REQ-009 SHALL have port rom_data, input, 16, the ROM entry, valid one cycle after rom_addr: {note[15:10], duration[9:4], metadata[3:1], last[0]}.
REQ-010 SHALL have port note_to_load, output, 6, the note to the note player; 0 is a rest.
REQ-011 SHALL have port metadata, output, 3, the waveform select to the note player.
REQ-012 SHALL have port load_new_note, output, 1, a one-cycle load strobe to the note player.
REQ-013 SHALL have port play_enable, output, 1, the note player enable.
REQ-014 SHALL have port song_done, output, 1, a level that is high in DONE.

Function
REQ-015 SHALL implement the states IDLE, FETCH, LOAD, PLAY and DONE.
REQ-016 SHALL move IDLE->FETCH when play=1, otherwise stay in IDLE.
REQ-017 SHALL drive rom_addr from the address register in FETCH and move FETCH->LOAD unconditionally after one cycle.
REQ-018 SHALL, in LOAD when duration!=0, latch note, metadata, duration and last, pulse load_new_note for exactly one cycle, clear beat_cnt, and move to PLAY.
REQ-019 SHALL, in LOAD when duration==0, treat the entry as an end marker: no load_new_note, and move to DONE (LOOP=0) or to FETCH at address 0 (LOOP=1).
REQ-020 SHALL count in PLAY only on beat while play=1; beats while play=0 are dropped.
REQ-021 SHALL detect note end on the beat where beat_cnt+1==duration.
REQ-022 SHALL, at note end with last=0 and rom_addr!=max, increment the address and move to FETCH.
REQ-023 SHALL, at note end with last=1 or rom_addr==max, move to DONE if LOOP=0, or set the address to 0 and move to FETCH if LOOP=1.
REQ-024 SHALL drive play_enable=1 only in PLAY with play=1, and 0 otherwise, so a pause mutes the note and freezes it in place.
REQ-025 SHALL keep the inter-note gap (PLAY->FETCH->LOAD->PLAY) at exactly 2 cycles.
REQ-026 SHALL stay in DONE until restart or reset; restart in DONE moves to FETCH at address 0.
REQ-027 SHALL give restart priority over beat and play in every state: address=0, beat_cnt=0, next state FETCH, and no load_new_note that cycle.
REQ-028 SHALL size beat_cnt at 6 bits, never allow it to exceed duration-1, and wrap the address only through REQ-023.

Reset
REQ-029 SHALL, on asynchronous reset assertion, immediately go to IDLE with rom_addr=0, beat_cnt=0, note_to_load=0, metadata=0, load_new_note=0, play_enable=0 and song_done=0.
REQ-030 SHALL, on reset asserted mid-note, abandon the note without a further load_new_note and restart from address 0 on the next play.

Structure
REQ-031 SHALL place the state encoding, the rom_data field offsets and the REST note constant (0) in a shared package.
REQ-032 SHALL instantiate one sub-module, beat_counter, a 6-bit counter with clear, enable and terminal-count compare against duration.

Verification
REQ-033 SHALL cover: ROM {40,d=2,last=0},{44,d=1,last=1}, play=1 -> load_new_note with note 40, 2 beats, 2-cycle gap, note 44, 1 beat, then song_done=1 and no further loads.
REQ-034 SHALL cover: pause by dropping play for 3 beats during a d=4 note -> play_enable=0 while paused, and the note ends after 4 counted beats.
REQ-035 SHALL cover: restart pulse coinciding with beat at address 1 -> rom_addr=0 in FETCH and beat_cnt not incremented.
REQ-036 SHALL cover: LOOP=1 with a last entry at address 2 -> rom_addr returns to 0 and song_done stays 0.
REQ-037 SHALL cover: duration=0 entry at address 3 with LOOP=0 -> DONE and no load_new_note for that entry.
REQ-038 SHALL cover: asynchronous reset mid-PLAY -> all outputs 0 within the same cycle, and play restarts from address 0.
